vga_timing_porch: RTL
=====================

Name: vga_timing_porch

Overview:
Self-contained VGA timing generator and output stage. It owns the horizontal and vertical pixel counters and drives coordinates to an external pixel source. It receives that source's colour after a fixed, parametrised latency. It outputs colour, sync and active signals that are mutually aligned, with blanking and sync polarity applied. It sits between the pixel/pattern logic and the board VGA pins, and supersedes the purely combinational porch stage.

Parameters:
COLOR_BITS, 3, bits per colour channel
COORD_BITS, 11, width of x/y counters; must hold WIDTH-1 and HEIGHT-1
WIDTH, 800, total pixels per line
HEIGHT, 525, total lines per frame
WIDTH_ACTIVE, 640, visible pixels per line
HEIGHT_ACTIVE, 480, visible lines per frame
FRONT_PORCH_X, 18, pixels between active region and hsync pulse
BACK_PORCH_X, 50, pixels between hsync pulse and line end
FRONT_PORCH_Y, 10, lines between active region and vsync pulse
BACK_PORCH_Y, 33, lines between vsync pulse and frame end
HSYNC_ACTIVE_LOW, 1, 1: hsync pulse drives 0; 0: pulse drives 1
VSYNC_ACTIVE_LOW, 1, same for vsync
PIXEL_LATENCY, 2, enabled steps from o_x/o_y to valid i_red/i_green/i_blue (0..15)

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_enable  in  1  pixel-step enable; all state advances only when 1
o_x  out  COORD_BITS  current column for pixel source
o_y  out  COORD_BITS  current line for pixel source
o_frame_start  out  1  1 when o_x==0, o_y==0 and i_enable==1
i_red  in  COLOR_BITS  red from pixel source
i_green  in  COLOR_BITS  green from pixel source
i_blue  in  COLOR_BITS  blue from pixel source
o_red  out  COLOR_BITS  blanked, aligned red
o_green  out  COLOR_BITS  blanked, aligned green
o_blue  out  COLOR_BITS  blanked, aligned blue
o_hsync  out  1  aligned hsync at configured polarity
o_vsync  out  1  aligned vsync at configured polarity
o_active  out  1  aligned active-region flag

Behaviour:
- One clock (i_clk); reset is synchronous and active-high (i_reset); no other clocks or async resets.
- Reset values: o_x=0, o_y=0, o_red/o_green/o_blue=0, o_active=0.
- Reset values: o_hsync=HSYNC_ACTIVE_LOW, o_vsync=VSYNC_ACTIVE_LOW (the idle level).
- Reset clears every delay-line stage to active=0 and sync deasserted. Reset mid-frame restarts at (0,0) on the next clock.
- Counters: on an enabled edge, x increments; at x==WIDTH-1, x wraps to 0 and y increments. At y==HEIGHT-1 together with x==WIDTH-1, y wraps to 0. When i_enable=0, all registers hold.
- o_x/o_y are the counter registers directly (zero latency).
- Raw timing at counter (x,y):
  - active = x<WIDTH_ACTIVE && y<HEIGHT_ACTIVE
  - hpulse = WIDTH_ACTIVE+FRONT_PORCH_X <= x < WIDTH-BACK_PORCH_X
  - vpulse = HEIGHT_ACTIVE+FRONT_PORCH_Y <= y < HEIGHT-BACK_PORCH_Y
- Output sync level = pulse XOR polarity parameter: active-low gives 0 inside the pulse, 1 outside.
- Alignment:
  - The pixel source must present colour for coordinate k on the enabled edge PIXEL_LATENCY steps after k appears on o_x/o_y.
  - Raw active/hsync/vsync pass through a PIXEL_LATENCY-deep enabled shift register, so they reach the output stage on that same edge.
  - The final output register captures colour ANDed with the delayed active flag, plus the delayed syncs.
  - Total lag from counter to pins = PIXEL_LATENCY+1 enabled steps for every output.
- PIXEL_LATENCY=0: the delay line is absent, and colour may be combinational from o_x/o_y.
- Blanking: colour outputs are 0 whenever the aligned active flag is 0, regardless of input.
- o_frame_start is combinational from the counter registers and i_enable; it pulses once per frame.
- Parameter legality (elaboration check): WIDTH_ACTIVE+FRONT_PORCH_X < WIDTH-BACK_PORCH_X; HEIGHT_ACTIVE+FRONT_PORCH_Y < HEIGHT-BACK_PORCH_Y.

Decomposition:
- Package vga_timing_pkg:
  - default 640x480@60 constants (800/525/640/480/18/50/10/33);
  - COORD_BITS default;
  - polarity constants SYNC_ACTIVE_LOW/SYNC_ACTIVE_HIGH.
- Sub-module vga_delay_line: parametrised DEPTH x WIDTH shift register with enable and synchronous reset to a RESET_VALUE parameter. It is instantiated once for {active,hpulse,vpulse}.

Test Plan:
- Reset, then hold: i_reset=1 for 3 clocks -> o_x=0, o_y=0, o_hsync=1, o_vsync=1, o_active=0, colours 0; these hold while i_enable=0.
- Hsync timing (defaults, i_enable=1, PIXEL_LATENCY=2):
  - o_hsync goes low 3 clocks after o_x==658;
  - it stays low for 92 clocks;
  - line period is 800 clocks.
- Vsync and frame:
  - o_vsync is low for exactly 2 lines (1600 clocks), starting 3 clocks after (x=0,y=490);
  - o_frame_start recurs every 420000 clocks.
- Blanking and alignment:
  - pixel source returns i_red=o_x[2:0] delayed 2 steps;
  - o_red equals x mod 8 for x<640, aligned with o_active=1;
  - o_red=0 for x>=640 and for all of y>=480.
- Enable gating:
  - toggle i_enable every other clock -> counter and sync periods double (line = 1600 clocks);
  - outputs are unchanged on disabled cycles.
- Polarity and reset mid-frame:
  - HSYNC_ACTIVE_LOW=0 -> o_hsync high only in the pulse, otherwise identical timing;
  - assert i_reset at (x=300,y=200) -> next clock (0,0) and all outputs at reset values.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA timing block: default 640x480@60 geometry and sync polarities.
// Also holds the elaboration-time porch legality helper.
package vga_timing_pkg;

  localparam int unsigned DEF_COORD_BITS    = 11;
  localparam int unsigned DEF_WIDTH         = 800;
  localparam int unsigned DEF_HEIGHT        = 525;
  localparam int unsigned DEF_WIDTH_ACTIVE  = 640;
  localparam int unsigned DEF_HEIGHT_ACTIVE = 480;
  localparam int unsigned DEF_FRONT_PORCH_X = 18;
  localparam int unsigned DEF_BACK_PORCH_X  = 50;
  localparam int unsigned DEF_FRONT_PORCH_Y = 10;
  localparam int unsigned DEF_BACK_PORCH_Y  = 33;

  localparam bit SYNC_ACTIVE_LOW  = 1'b1;
  localparam bit SYNC_ACTIVE_HIGH = 1'b0;

  // A sync pulse must have at least one pixel between the two porches.
  function automatic bit legal_porch(input int unsigned active, input int unsigned front,
                                     input int unsigned back, input int unsigned total);
    return (active + front) < (total - back);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enabled shift register of DEPTH stages, each WIDTH bits, with synchronous reset.
module vga_delay_line #(
  parameter int unsigned     DEPTH       = 1,
  parameter int unsigned     WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_stage[i] <= RESET_VALUE;
      end
    end else if (i_enable) begin
      r_stage[0] <= i_data;
      for (int i = 1; i < int'(DEPTH); i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_porch.sv
// VGA timing generator and output stage: counters, raw sync/active decode, a delay line matching
// the pixel source latency, and a final register applying blanking and sync polarity.
module vga_timing_porch
  import vga_timing_pkg::*;
#(
  parameter int unsigned COLOR_BITS       = 3,
  parameter int unsigned COORD_BITS       = DEF_COORD_BITS,
  parameter int unsigned WIDTH            = DEF_WIDTH,
  parameter int unsigned HEIGHT           = DEF_HEIGHT,
  parameter int unsigned WIDTH_ACTIVE     = DEF_WIDTH_ACTIVE,
  parameter int unsigned HEIGHT_ACTIVE    = DEF_HEIGHT_ACTIVE,
  parameter int unsigned FRONT_PORCH_X    = DEF_FRONT_PORCH_X,
  parameter int unsigned BACK_PORCH_X     = DEF_BACK_PORCH_X,
  parameter int unsigned FRONT_PORCH_Y    = DEF_FRONT_PORCH_Y,
  parameter int unsigned BACK_PORCH_Y     = DEF_BACK_PORCH_Y,
  parameter bit          HSYNC_ACTIVE_LOW = SYNC_ACTIVE_LOW,
  parameter bit          VSYNC_ACTIVE_LOW = SYNC_ACTIVE_LOW,
  parameter int unsigned PIXEL_LATENCY    = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  output logic [COORD_BITS-1:0] o_x,
  output logic [COORD_BITS-1:0] o_y,
  output logic                  o_frame_start,
  input  logic [COLOR_BITS-1:0] i_red,
  input  logic [COLOR_BITS-1:0] i_green,
  input  logic [COLOR_BITS-1:0] i_blue,
  output logic [COLOR_BITS-1:0] o_red,
  output logic [COLOR_BITS-1:0] o_green,
  output logic [COLOR_BITS-1:0] o_blue,
  output logic                  o_hsync,
  output logic                  o_vsync,
  output logic                  o_active
);

  if (!legal_porch(WIDTH_ACTIVE, FRONT_PORCH_X, BACK_PORCH_X, WIDTH) ||
      !legal_porch(HEIGHT_ACTIVE, FRONT_PORCH_Y, BACK_PORCH_Y, HEIGHT) ||
      PIXEL_LATENCY > 15 || WIDTH > (1 << COORD_BITS) || HEIGHT > (1 << COORD_BITS))
  begin : g_bad_params
    $error("vga_timing_porch: illegal timing parameters");
  end

  localparam logic [COORD_BITS-1:0] X_LAST     = COORD_BITS'(WIDTH - 1);
  localparam logic [COORD_BITS-1:0] Y_LAST     = COORD_BITS'(HEIGHT - 1);
  localparam logic [COORD_BITS-1:0] X_ACT      = COORD_BITS'(WIDTH_ACTIVE);
  localparam logic [COORD_BITS-1:0] Y_ACT      = COORD_BITS'(HEIGHT_ACTIVE);
  localparam logic [COORD_BITS-1:0] X_HS_START = COORD_BITS'(WIDTH_ACTIVE + FRONT_PORCH_X);
  localparam logic [COORD_BITS-1:0] X_HS_END   = COORD_BITS'(WIDTH - BACK_PORCH_X);
  localparam logic [COORD_BITS-1:0] Y_VS_START = COORD_BITS'(HEIGHT_ACTIVE + FRONT_PORCH_Y);
  localparam logic [COORD_BITS-1:0] Y_VS_END   = COORD_BITS'(HEIGHT - BACK_PORCH_Y);

  logic [COORD_BITS-1:0] r_x, r_y;
  logic [COORD_BITS-1:0] w_x_next, w_y_next;
  logic                  w_active, w_hpulse, w_vpulse;
  logic [2:0]            w_raw, w_dly;
  logic [COLOR_BITS-1:0] r_red, r_green, r_blue;
  logic                  r_hsync, r_vsync, r_active;

  always_comb begin
    w_x_next = r_x + 1'b1;
    w_y_next = r_y;
    if (r_x == X_LAST) begin
      w_x_next = '0;
      w_y_next = (r_y == Y_LAST) ? '0 : r_y + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_enable) begin
      r_x <= w_x_next;
      r_y <= w_y_next;
    end
  end

  assign w_active = (r_x < X_ACT) && (r_y < Y_ACT);
  assign w_hpulse = (r_x >= X_HS_START) && (r_x < X_HS_END);
  assign w_vpulse = (r_y >= Y_VS_START) && (r_y < Y_VS_END);
  assign w_raw    = {w_active, w_hpulse, w_vpulse};

  // Delayed flags stay as pulses (not pin levels) so reset clears them to "no sync".
  if (PIXEL_LATENCY == 0) begin : g_no_delay
    assign w_dly = w_raw;
  end else begin : g_delay
    vga_delay_line #(
      .DEPTH       (PIXEL_LATENCY),
      .WIDTH       (3),
      .RESET_VALUE (3'b000)
    ) u_delay (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_enable (i_enable),
      .i_data   (w_raw),
      .o_data   (w_dly)
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_red    <= '0;
      r_green  <= '0;
      r_blue   <= '0;
      r_active <= 1'b0;
      r_hsync  <= HSYNC_ACTIVE_LOW;
      r_vsync  <= VSYNC_ACTIVE_LOW;
    end else if (i_enable) begin
      r_red    <= i_red   & {COLOR_BITS{w_dly[2]}};
      r_green  <= i_green & {COLOR_BITS{w_dly[2]}};
      r_blue   <= i_blue  & {COLOR_BITS{w_dly[2]}};
      r_active <= w_dly[2];
      r_hsync  <= w_dly[1] ^ HSYNC_ACTIVE_LOW;
      r_vsync  <= w_dly[0] ^ VSYNC_ACTIVE_LOW;
    end
  end

  assign o_x           = r_x;
  assign o_y           = r_y;
  assign o_frame_start = (r_x == '0) && (r_y == '0) && i_enable;
  assign o_red         = r_red;
  assign o_green       = r_green;
  assign o_blue        = r_blue;
  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_active      = r_active;

endmodule
